// File: rtl/dmem_responder.sv
// dmem_responder: responder side of a valid/ready data-memory port.
// Serves one load or store word at a time with a fixed, configurable
// latency over an internal 32-bit word array.
// Optional build macro: DMEM_MISALIGN_CHECK_EN. When defined, a request with
// req_addr[1:0] != 0 skips the array and reports resp_err=1 with zero data.
// When undefined, the low address bits are ignored and resp_err is always 0.
// Note: rst is an asynchronous, active-low reset.
module dmem_responder #(
  parameter int LATENCY = 3,     // 1..15
  parameter int DEPTH   = 1024,  // power of two
  parameter int AW      = 10     // log2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  // Word storage; deliberately not reset.
  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic [AW+1:0] eff_addr;
  logic          eff_we;
  logic [31:0]   eff_wdata;
  logic [AW-1:0] eff_idx;
  logic          misalign;
  logic          mem_we;
  logic          unused_bits;

  // Handshake events and the request seen at the RESP-entry edge. With
  // LATENCY=1 the entry edge is the acceptance edge itself, so the live
  // request inputs are used instead of the captured copy.
  always_comb begin
    accept     = (state_q == ST_IDLE) && req_valid;
    enter_resp = (accept && (LATENCY == 1)) ||
                 ((state_q == ST_WAIT) && (cnt_q == 4'd1));
    if (state_q == ST_IDLE) begin
      eff_addr  = req_addr[AW+1:0];
      eff_we    = req_we;
      eff_wdata = req_wdata;
    end else begin
      eff_addr  = addr_q;
      eff_we    = we_q;
      eff_wdata = wdata_q;
    end
    eff_idx = eff_addr[AW+1:2];
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign = (eff_addr[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    // A store commits only on a RESP-entry edge outside reset.
    mem_we = rst && enter_resp && eff_we && !misalign;
  end

  // Upper address bits wrap; low bits only matter for the misalign check.
  assign unused_bits = ^{req_addr[31:AW+2], eff_addr[1:0]};

  // Array write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[eff_idx] <= eff_wdata;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: only IDLE accepts, only RESP presents a response.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    busy       = (state_q != ST_IDLE);
  end

  // Request capture, latency counter and response data next-values.
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      cnt_d   = 4'(LATENCY - 1);
      addr_d  = req_addr[AW+1:0];
      we_d    = req_we;
      wdata_d = req_wdata;
    end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (enter_resp) begin
      rdata_d = (eff_we || misalign) ? 32'h0 : mem[eff_idx];
      err_d   = misalign;
    end
  end

  // Datapath registers; response data holds while in RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign resp_rdata = rdata_q;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder (LATENCY=3, DEPTH=1024).
module tb_dmem_responder;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        req_we = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;
  int acc_cnt = 0;

  dmem_responder #(.LATENCY(LAT), .DEPTH(1024), .AW(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Count request handshakes seen by the responder.
  always @(posedge clk) begin
    if (rst && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction: present request, measure latency, optionally
  // stall the response for 'hold' cycles, then complete the handshake.
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int hold, input bit keep_valid);
    int w;
    int lat;
    int rdy_bad;
    int unstable;
    logic [31:0] r0;
    logic e0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    w = 0;
    while (req_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check_vec({tag, "_accept_wait"}, 32'(w < 40), 32'd1);
    @(posedge clk);
    #1;
    if (!keep_valid) req_valid = 1'b0;
    lat = 1;
    rdy_bad = 0;
    while (resp_valid !== 1'b1 && lat < 40) begin
      if (req_ready !== 1'b0 || busy !== 1'b1) rdy_bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    check_vec({tag, "_latency"}, 32'(lat), 32'(LAT));
    check_vec({tag, "_rdata"}, resp_rdata, exp_rdata);
    check_vec({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    r0 = resp_rdata;
    e0 = resp_err;
    unstable = 0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      if (resp_valid !== 1'b1 || resp_rdata !== r0 || resp_err !== e0) unstable++;
      if (req_ready !== 1'b0) rdy_bad++;
    end
    if (hold > 0) check_vec({tag, "_hold_stable"}, 32'(unstable), 32'd0);
    check_vec({tag, "_ready_low"}, 32'(rdy_bad), 32'd0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check_vec({tag, "_idle_after"}, {29'd0, req_ready, resp_valid, busy}, 32'h4);
    $display("txn %s we=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
             tag, we, addr, wdata, r0, e0, lat);
  endtask

  initial begin
    int acc0;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_vec("rst_req_ready", 32'(req_ready), 32'd1);
    check_vec("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_vec("rst_busy", 32'(busy), 32'd0);
    check_vec("rst_rdata", resp_rdata, 32'h0);
    check_vec("rst_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Store then load back
    do_req("st10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 1'b0);
    do_req("ld10_hold", 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 5, 1'b0);

    // Address wrap: 0x1004 aliases 0x0004
    do_req("st1004", 1'b1, 32'h0000_1004, 32'h1234_5678, 32'h0, 1'b0, 0, 1'b0);
    do_req("ld4", 1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678, 1'b0, 0, 1'b0);

    // Prime 0x20, then abort a store to it with reset
    do_req("st20", 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 32'h0, 1'b0, 0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0000_0020;
    req_wdata = 32'hAAAA_5555;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    check_vec("abort_accepted", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_vec("abort_req_ready", 32'(req_ready), 32'd1);
    check_vec("abort_resp_valid", 32'(resp_valid), 32'd0);
    check_vec("abort_busy", 32'(busy), 32'd0);
    check_vec("abort_rdata", resp_rdata, 32'h0);
    check_vec("abort_err", 32'(resp_err), 32'd0);
    $display("txn abort_st20 reset asserted mid-request");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_req("ld20_after_abort", 1'b0, 32'h0000_0020, 32'h0, 32'h0BAD_F00D, 1'b0, 0, 1'b0);

    // Back-to-back loads with req_valid held high
    acc0 = acc_cnt;
    do_req("bb0", 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 1'b1);
    do_req("bb1", 1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678, 1'b0, 2, 1'b1);
    do_req("bb2", 1'b0, 32'h0000_0020, 32'h0, 32'h0BAD_F00D, 1'b0, 0, 1'b1);
    do_req("bb3", 1'b0, 32'h0000_1010, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_vec("bb_accept_count", 32'(acc_cnt - acc0), 32'd4);

    // Misaligned store
`ifdef DMEM_MISALIGN_CHECK_EN
    do_req("st22_mis", 1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 32'h0, 1'b1, 0, 1'b0);
    do_req("ld20_mis", 1'b0, 32'h0000_0020, 32'h0, 32'h0BAD_F00D, 1'b0, 0, 1'b0);
`else
    do_req("st22_mis", 1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 32'h0, 1'b0, 0, 1'b0);
    do_req("ld20_mis", 1'b0, 32'h0000_0020, 32'h0, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
